array_input_skewer: RTL and testbench

- Operand loader directly upstream of the systolic array controller/array.
- Accepts one N×N operand tile from the DMA as N column beats over a valid/ready stream and holds it in a tile register.
- On start, feeds the tile into the array's N row lanes as a skewed wavefront: lane r is delayed r cycles. This produces the diagonal operand timing the systolic array needs.

---
 rtl/array_input_skewer_if.sv | 28 ++
 rtl/array_input_skewer.sv | 98 +++++++++
 tb/tb_array_input_skewer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/array_input_skewer_if.sv
// Operand-loader bus bundle: DMA beat stream in, skewed wavefront stream out,
// plus the controller's flush/start/full/done sideband.
interface array_input_skewer_if #(
  parameter int N  = 4,
  parameter int DW = 8
);
  logic            i_s_valid;
  logic [N*DW-1:0] i_s_data;
  logic            o_s_ready;
  logic            i_flush;
  logic            o_tile_full;
  logic            i_start;
  logic            i_arr_ready;
  logic            o_arr_valid;
  logic [N*DW-1:0] o_arr_data;
  logic [N-1:0]    o_arr_lane_valid;
  logic            o_done;

  modport master (
    output i_s_valid, i_s_data, i_flush, i_start, i_arr_ready,
    input  o_s_ready, o_tile_full, o_arr_valid, o_arr_data, o_arr_lane_valid, o_done
  );

  modport slave (
    input  i_s_valid, i_s_data, i_flush, i_start, i_arr_ready,
    output o_s_ready, o_tile_full, o_arr_valid, o_arr_data, o_arr_lane_valid, o_done
  );
endinterface

// File: rtl/array_input_skewer.sv
// Loads an NxN operand tile column by column, then feeds it to the systolic
// array as a diagonal wavefront where lane r lags lane 0 by r cycles.
module array_input_skewer #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  array_input_skewer_if.slave  bus
);
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = (N > 1) ? $clog2(2*N-1) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N-1);
  localparam logic [TW-1:0] T_LAST = TW'(2*N-2);

  typedef enum logic [1:0] {LOAD, FULL, FEED} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [KW-1:0]   r_k;
  logic [TW-1:0]   r_t;
  logic            r_done;
  logic [DW-1:0]   r_tile [N][N];
  logic            w_beat;
  logic            w_last_acc;
  logic [N*DW-1:0] w_lane_data;
  logic [N-1:0]    w_lane_vld;

  always_comb begin
    w_beat     = (r_state == LOAD) && bus.i_s_valid;
    w_last_acc = (r_state == FEED) && bus.i_arr_ready && (r_t == T_LAST);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= LOAD;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (bus.i_flush) begin
      w_next = LOAD;
    end else begin
      case (r_state)
        LOAD:    if (w_beat && (r_k == K_LAST)) w_next = FULL;
        FULL:    if (bus.i_start)                w_next = FEED;
        FEED:    if (w_last_acc)                 w_next = LOAD;
        default: w_next = LOAD;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_k    <= '0;
      r_t    <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last_acc && !bus.i_flush;
      if (bus.i_flush) begin
        r_k <= '0;
        r_t <= '0;
      end else begin
        if (w_beat) r_k <= (r_k == K_LAST) ? '0 : r_k + KW'(1);
        if (r_state == FULL)
          r_t <= '0;
        else if ((r_state == FEED) && bus.i_arr_ready)
          r_t <= w_last_acc ? '0 : r_t + TW'(1);
      end
    end
  end

  // Tile storage carries no reset: its contents are only read after a full load.
  always_ff @(posedge i_clk) begin
    if (w_beat && !bus.i_flush) begin
      for (int unsigned r = 0; r < N; r++)
        r_tile[r][r_k] <= bus.i_s_data[r*DW +: DW];
    end
  end

  // Lane g shows column t-g of row g while that column index lies in [0, N-1].
  for (genvar g = 0; g < N; g++) begin : g_lane
    localparam logic [TW-1:0] LANE = TW'(g);
    logic [TW-1:0] w_col;
    assign w_col = r_t - LANE;
    assign w_lane_vld[g] = (r_state == FEED) && (r_t >= LANE) && (w_col <= TW'(N-1));
    assign w_lane_data[g*DW +: DW] = w_lane_vld[g] ? r_tile[g][w_col[KW-1:0]] : '0;
  end

  always_comb begin
    bus.o_s_ready        = (r_state == LOAD) && i_rst_n;
    bus.o_tile_full      = (r_state == FULL);
    bus.o_arr_valid      = (r_state == FEED);
    bus.o_arr_data       = w_lane_data;
    bus.o_arr_lane_valid = w_lane_vld;
    bus.o_done           = r_done;
  end
endmodule

// File: tb/tb_array_input_skewer.sv
// Randomized scoreboard bench for array_input_skewer: stimulus pushes expected
// wavefronts computed from the tile matrix, a negedge monitor pops and compares.
module tb_array_input_skewer;
  localparam int N  = 4;
  localparam int DW = 8;

  typedef struct {
    logic [N*DW-1:0] data;
    logic [N-1:0]    mask;
    bit              last;
  } wf_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   valid_cycles = 0;
  bit   done_due = 0;
  logic [DW-1:0] mA [N][N];
  wf_t  exp_q [$];

  array_input_skewer_if #(.N(N), .DW(DW)) bus ();

  array_input_skewer #(.N(N), .DW(DW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: wavefront t holds A[r][t-r] on lane r when 0 <= t-r < N.
  function automatic wf_t model_wf(input int t);
    wf_t w;
    w.data = '0;
    w.mask = '0;
    w.last = (t == 2*N-2);
    for (int r = 0; r < N; r++) begin
      if (t - r >= 0 && t - r < N) begin
        w.data[r*DW +: DW] = mA[r][t-r];
        w.mask[r] = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic [N*DW-1:0] beat(input int k);
    logic [N*DW-1:0] d;
    for (int r = 0; r < N; r++) d[r*DW +: DW] = mA[r][k];
    return d;
  endfunction

  always @(negedge clk) begin
    wf_t w;
    if (bus.o_arr_valid === 1'b1) valid_cycles++;
    if (done_due) begin
      done_due = 0;
      checks++;
      if (bus.o_done !== 1'b1) begin
        failures++;
        $display("FAIL done_pulse: got %b expected 1", bus.o_done);
      end
    end else if (bus.o_done === 1'b1) begin
      checks++;
      failures++;
      $display("FAIL done_spurious: got 1 expected 0");
    end
    if (bus.o_arr_valid === 1'b1 && bus.i_arr_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wavefront_unexpected: got data 0x%0h expected none", bus.o_arr_data);
      end else begin
        w = exp_q.pop_front();
        if (bus.o_arr_data !== w.data || bus.o_arr_lane_valid !== w.mask) begin
          failures++;
          $display("FAIL wavefront: got data 0x%0h mask %b expected data 0x%0h mask %b",
                   bus.o_arr_data, bus.o_arr_lane_valid, w.data, w.mask);
        end
        if (w.last) done_due = 1;
      end
    end
  end

  task automatic rand_tile();
    for (int r = 0; r < N; r++)
      for (int k = 0; k < N; k++) mA[r][k] = DW'($urandom);
  endtask

  task automatic send_beat(input logic [N*DW-1:0] d, input bit with_start);
    int w = 0;
    bus.i_s_valid = 1'b1;
    bus.i_s_data  = d;
    bus.i_start   = with_start;
    while (bus.o_s_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    if (w == 50) chk("beat_ready_timeout", 0, 1);
    tick();
    bus.i_s_valid = 1'b0;
    bus.i_start   = 1'b0;
  endtask

  task automatic load_tile(input bit gaps, input bit start_pulses);
    for (int k = 0; k < N; k++) begin
      send_beat(beat(k), start_pulses && (k == 1 || k == N-1));
      chk("tile_full_after_beat", bus.o_tile_full, (k == N-1) ? 1 : 0);
      if (gaps && k != N-1) tick();
    end
    chk("s_ready_when_full", bus.o_s_ready, 0);
  endtask

  task automatic run_feed(input int stall_at, input int stall_len, input int flush_at);
    int vc0;
    vc0 = valid_cycles;
    for (int t = 0; t < 2*N-1; t++)
      if (flush_at < 0 || t < flush_at) exp_q.push_back(model_wf(t));
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    for (int t = 0; t < 2*N-1; t++) begin
      if (t == flush_at) begin
        bus.i_arr_ready = 1'b0;
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        bus.i_arr_ready = 1'b1;
        chk("flush_feed_arr_valid", bus.o_arr_valid, 0);
        chk("flush_feed_s_ready", bus.o_s_ready, 1);
        chk("flush_feed_done", bus.o_done, 0);
        tick();
        return;
      end
      if (t == stall_at) begin
        bus.i_arr_ready = 1'b0;
        repeat (stall_len) begin
          chk("stall_hold_data", bus.o_arr_data, model_wf(t).data);
          chk("stall_hold_valid", bus.o_arr_valid, 1);
          tick();
        end
        bus.i_arr_ready = 1'b1;
      end
      tick();
    end
    chk("feed_end_s_ready", bus.o_s_ready, 1);
    chk("feed_end_arr_valid", bus.o_arr_valid, 0);
    chk("feed_valid_cycles", valid_cycles - vc0, 2*N-1+stall_len);
    tick();
  endtask

  task automatic run_feed_rand();
    int acc = 0;
    int cyc = 0;
    bit ar;
    for (int t = 0; t < 2*N-1; t++) exp_q.push_back(model_wf(t));
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    while (acc < 2*N-1 && cyc < 200) begin
      ar = 1'($urandom_range(0, 1));
      bus.i_arr_ready = ar;
      tick();
      if (ar) acc++;
      cyc++;
    end
    bus.i_arr_ready = 1'b1;
    if (cyc == 200) chk("rand_feed_timeout", 0, 1);
    chk("rand_feed_end_valid", bus.o_arr_valid, 0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.i_s_valid = 1'b0;
    bus.i_s_data = '0;
    bus.i_flush = 1'b0;
    bus.i_start = 1'b0;
    bus.i_arr_ready = 1'b1;
    tick();
    tick();
    chk("rst_s_ready", bus.o_s_ready, 0);
    chk("rst_tile_full", bus.o_tile_full, 0);
    chk("rst_arr_valid", bus.o_arr_valid, 0);
    chk("rst_arr_data", bus.o_arr_data, 0);
    chk("rst_lane_valid", bus.o_arr_lane_valid, 0);
    chk("rst_done", bus.o_done, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_s_ready", bus.o_s_ready, 1);

    // Reference tile: element r of beat k is {k, r} nibbles.
    for (int r = 0; r < N; r++)
      for (int k = 0; k < N; k++) mA[r][k] = DW'(k*16 + r);
    load_tile(0, 0);
    run_feed(-1, 0, -1);

    load_tile(0, 0);
    run_feed(2, 3, -1);

    rand_tile();
    load_tile(1, 0);
    run_feed(-1, 0, -1);

    rand_tile();
    load_tile(0, 1);
    repeat (3) tick();
    chk("start_ignored_full", bus.o_tile_full, 1);
    chk("start_ignored_no_feed", bus.o_arr_valid, 0);
    run_feed(-1, 0, -1);

    rand_tile();
    load_tile(0, 0);
    run_feed(-1, 0, 4);

    rand_tile();
    send_beat(beat(0), 0);
    send_beat(beat(1), 0);
    bus.i_s_valid = 1'b1;
    bus.i_s_data = beat(2);
    bus.i_flush = 1'b1;
    tick();
    bus.i_s_valid = 1'b0;
    bus.i_flush = 1'b0;
    chk("flush_load_s_ready", bus.o_s_ready, 1);
    chk("flush_load_full", bus.o_tile_full, 0);
    rand_tile();
    load_tile(0, 0);
    run_feed(-1, 0, -1);

    rand_tile();
    load_tile(0, 0);
    exp_q.push_back(model_wf(0));
    exp_q.push_back(model_wf(1));
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    tick();
    tick();
    bus.i_arr_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midfeed_rst_s_ready", bus.o_s_ready, 0);
    tick();
    chk("midfeed_rst_arr_valid", bus.o_arr_valid, 0);
    chk("midfeed_rst_data", bus.o_arr_data, 0);
    chk("midfeed_rst_mask", bus.o_arr_lane_valid, 0);
    chk("midfeed_rst_full", bus.o_tile_full, 0);
    chk("midfeed_rst_done", bus.o_done, 0);
    rst_n = 1'b1;
    bus.i_arr_ready = 1'b1;
    tick();
    chk("midfeed_post_rst_ready", bus.o_s_ready, 1);
    for (int i = 0; i < 2; i++) begin
      rand_tile();
      load_tile(0, 0);
      run_feed(-1, 0, -1);
    end

    for (int i = 0; i < 6; i++) begin
      rand_tile();
      load_tile(1'($urandom_range(0, 1)), 0);
      repeat ($urandom_range(0, 3)) tick();
      run_feed_rand();
    end

    repeat (3) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
